// File: rtl/flash_emulator_if.sv
// Parallel NOR flash pin bundle between the flash bridge (master) and the
// device or its emulator (slave).
interface flash_emulator_if #(
  parameter int ADDR_W = 12
);
  logic              NF_CE;
  logic              NF_OE;
  logic              NF_WE;
  logic              NF_RP;
  logic              NF_WP;
  logic [ADDR_W-1:0] NF_A;
  logic [7:0]        NF_D_IN;
  logic [7:0]        NF_D_OUT;
  logic              NF_D_OE;
  logic              NF_STS;

  modport master (
    output NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_A, NF_D_IN,
    input  NF_D_OUT, NF_D_OE, NF_STS
  );

  modport slave (
    input  NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_A, NF_D_IN,
    output NF_D_OUT, NF_D_OE, NF_STS
  );
endinterface

// File: rtl/flash_emulator.sv
// Byte-wide StrataFlash-style NOR flash responder backed by an internal RAM array.
// Define FLASH_EMU_READ_ID_EN to add the 8'h90 READ_ID command and DEVICE_ID parameter.
module flash_emulator #(
  parameter int ADDR_W      = 12,
  parameter int BLOCK_W     = 8,
  parameter int PROG_CYCLES = 16
`ifdef FLASH_EMU_READ_ID_EN
  , parameter logic [7:0] DEVICE_ID = 8'h16
`endif
) (
  input logic             CLK_50MHZ,
  input logic             RST,
  flash_emulator_if.slave nf
);
  localparam int PC_W  = $clog2(PROG_CYCLES + 1);
  localparam int CNT_W = (PC_W > BLOCK_W) ? PC_W : BLOCK_W;

  typedef enum logic [2:0] {
    READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE, READ_ID
  } mode_t;

  // Bytes are stored inverted so a zero-initialised RAM reads back as erased 8'hFF.
  logic [7:0]        mem_n [2**ADDR_W];
  mode_t             mode;
  logic [7:0]        sr;
  logic              sts_q;
  logic              d_oe_q;
  logic [7:0]        d_out_q;
  logic              wr_armed;
  logic [ADDR_W-1:0] a_cap;
  logic [7:0]        d_cap;
  logic [ADDR_W-1:0] op_addr;
  logic [7:0]        op_dat;
  logic [CNT_W-1:0]  cnt;
  logic              rst_any;
  logic              wr_evt;
  logic              rd_act;
  logic              blk_prot;
  logic [7:0]        rd_dat;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [7:0]        mem_wd;

  assign rst_any  = RST || !nf.NF_RP;
  assign wr_evt   = wr_armed && nf.NF_WE;
  assign rd_act   = !nf.NF_CE && !nf.NF_OE && nf.NF_WE;
  assign blk_prot = !nf.NF_WP && (a_cap[ADDR_W-1:BLOCK_W] == '0 ||
                                  a_cap[ADDR_W-1:BLOCK_W] == '1);

  assign nf.NF_D_OUT = d_out_q;
  assign nf.NF_D_OE  = d_oe_q;
  assign nf.NF_STS   = sts_q;

  always_comb begin
    rd_dat = sr;
    case (mode)
      READ_ARRAY: rd_dat = ~mem_n[nf.NF_A];
`ifdef FLASH_EMU_READ_ID_EN
      READ_ID:    rd_dat = nf.NF_A[0] ? DEVICE_ID : 8'h89;
`endif
      default:    rd_dat = sr;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = op_addr;
    mem_wd = 8'h00;
    if (mode == BUSY_PROG && cnt == '0) begin
      mem_we = 1'b1;
      mem_wd = mem_n[op_addr] | ~op_dat;
    end else if (mode == BUSY_ERASE) begin
      mem_we = 1'b1;
      mem_wa = {op_addr[ADDR_W-1:BLOCK_W], cnt[BLOCK_W-1:0]};
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!rst_any && mem_we)
      mem_n[mem_wa] <= mem_wd;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) wr_armed <= 1'b0;
    else     wr_armed <= !nf.NF_CE && !nf.NF_WE;
    if (!nf.NF_CE && !nf.NF_WE) begin
      a_cap <= nf.NF_A;
      d_cap <= nf.NF_D_IN;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rst_any) begin
      mode    <= READ_ARRAY;
      sr      <= 8'h80;
      sts_q   <= 1'b1;
      d_oe_q  <= 1'b0;
      d_out_q <= 8'h00;
      cnt     <= '0;
    end else begin
      d_oe_q <= rd_act;
      if (rd_act) d_out_q <= rd_dat;
      case (mode)
        READ_ARRAY, READ_STATUS, READ_ID: begin
          if (wr_evt) begin
            case (d_cap)
              8'hFF:        mode <= READ_ARRAY;
              8'h70:        mode <= READ_STATUS;
              8'h50: begin
                sr   <= sr & 8'hC1;
                mode <= READ_STATUS;
              end
              8'h40, 8'h10: mode <= PROG_SETUP;
              8'h20:        mode <= ERASE_SETUP;
`ifdef FLASH_EMU_READ_ID_EN
              8'h90:        mode <= READ_ID;
`endif
              default:      mode <= READ_ARRAY;
            endcase
          end
        end
        PROG_SETUP: begin
          if (wr_evt) begin
            if (blk_prot) begin
              sr   <= sr | 8'h12;
              mode <= READ_STATUS;
            end else begin
              op_addr <= a_cap;
              op_dat  <= d_cap;
              cnt     <= CNT_W'(PROG_CYCLES - 1);
              sr[7]   <= 1'b0;
              sts_q   <= 1'b0;
              mode    <= BUSY_PROG;
            end
          end
        end
        ERASE_SETUP: begin
          if (wr_evt) begin
            if (d_cap != 8'hD0) begin
              sr   <= sr | 8'h30;
              mode <= READ_STATUS;
            end else if (blk_prot) begin
              sr   <= sr | 8'h22;
              mode <= READ_STATUS;
            end else begin
              op_addr <= a_cap;
              cnt     <= '0;
              sr[7]   <= 1'b0;
              sts_q   <= 1'b0;
              mode    <= BUSY_ERASE;
            end
          end
        end
        BUSY_PROG: begin
          if (cnt == '0) begin
            sr[7] <= 1'b1;
            sts_q <= 1'b1;
            mode  <= READ_STATUS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BUSY_ERASE: begin
          cnt <= cnt + 1'b1;
          if (cnt[BLOCK_W-1:0] == '1) begin
            sr[7] <= 1'b1;
            sts_q <= 1'b1;
            mode  <= READ_STATUS;
          end
        end
        default: mode <= READ_ARRAY;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_emulator.sv
// Directed bench for flash_emulator: reads are scored against a queue of
// hand-computed bytes by an independent monitor; busy lengths are checked inline.
module tb_flash_emulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    string      nm;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  flash_emulator_if #(.ADDR_W(12)) nf();

  flash_emulator dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .nf        (nf)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT drives read data, pop and compare one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nf.NF_D_OE === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got=%02h expected=none", nf.NF_D_OUT);
        end else begin
          e = exp_q.pop_front();
          chk(e.nm, {24'h0, nf.NF_D_OUT}, {24'h0, e.val});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    nf.NF_A    = a;
    nf.NF_D_IN = d;
    nf.NF_CE   = 1'b0;
    nf.NF_WE   = 1'b0;
    @(posedge clk); #1;
    nf.NF_WE   = 1'b1;
    nf.NF_CE   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] exp, input string nm);
    exp_t e;
    e.nm  = nm;
    e.val = exp;
    exp_q.push_back(e);
    nf.NF_A  = a;
    nf.NF_CE = 1'b0;
    nf.NF_OE = 1'b0;
    @(posedge clk); #1;
    nf.NF_OE = 1'b1;
    nf.NF_CE = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input int exp_cycles, input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (nf.NF_STS === 1'b1 || n >= 2000) break;
      n++;
    end
    chk(nm, n, exp_cycles);
    @(posedge clk); #1;
  endtask

  task automatic prog(input logic [11:0] a, input logic [7:0] d, input string nm);
    wr(12'h000, 8'h40);
    wr(a, d);
    wait_rdy(16, nm);
  endtask

  initial begin
    nf.NF_CE   = 1'b1;
    nf.NF_OE   = 1'b1;
    nf.NF_WE   = 1'b1;
    nf.NF_RP   = 1'b1;
    nf.NF_WP   = 1'b1;
    nf.NF_A    = '0;
    nf.NF_D_IN = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_d_oe", nf.NF_D_OE, 1'b0);
    chk("reset_d_out", nf.NF_D_OUT, 8'h00);
    chk("reset_sts", nf.NF_STS, 1'b1);
    @(posedge clk); #1;

    // Read latency: output enable is not yet asserted in the cycle OE goes low.
    nf.NF_CE = 1'b0;
    nf.NF_OE = 1'b0;
    @(negedge clk);
    chk("read_latency_oe_low", nf.NF_D_OE, 1'b0);
    nf.NF_OE = 1'b1;
    nf.NF_CE = 1'b1;
    @(posedge clk); #1;
    rd(12'h000, 8'hFF, "read_erased_0x000");

    prog(12'h123, 8'hA5, "prog_busy_cycles");
    rd(12'h000, 8'h80, "status_after_prog");
    wr(12'h000, 8'hFF);
    rd(12'h123, 8'hA5, "read_prog_a5");

    prog(12'h123, 8'h3C, "prog2_busy_cycles");
    wr(12'h000, 8'hFF);
    rd(12'h123, 8'h24, "read_and_3c_a5");

    prog(12'h0FF, 8'h11, "prog_0ff_busy");
    prog(12'h200, 8'h22, "prog_200_busy");
    prog(12'h2F0, 8'h5A, "prog_2f0_busy");

    wr(12'h000, 8'h20);
    wr(12'h150, 8'hD0);
    wait_rdy(256, "erase_busy_cycles");
    rd(12'h000, 8'h80, "status_after_erase");
    wr(12'h000, 8'hFF);
    rd(12'h100, 8'hFF, "erased_0x100");
    rd(12'h123, 8'hFF, "erased_0x123");
    rd(12'h1FF, 8'hFF, "erased_0x1ff");
    rd(12'h0FF, 8'h11, "kept_0x0ff");
    rd(12'h200, 8'h22, "kept_0x200");

    wr(12'h000, 8'h20);
    wr(12'h000, 8'h55);
    wait_rdy(0, "bad_confirm_no_busy");
    rd(12'h000, 8'hB0, "status_bad_confirm");
    wr(12'h000, 8'h50);
    rd(12'h000, 8'h80, "status_after_clear");

    nf.NF_WP = 1'b0;
    wr(12'h000, 8'h40);
    wr(12'h010, 8'h77);
    wait_rdy(0, "protected_no_busy");
    rd(12'h000, 8'h92, "status_protected");
    wr(12'h000, 8'h50);
    wr(12'h000, 8'hFF);
    rd(12'h010, 8'hFF, "protected_unchanged");
    nf.NF_WP = 1'b1;

`ifdef FLASH_EMU_READ_ID_EN
    wr(12'h000, 8'h90);
    rd(12'h000, 8'h89, "read_id_mfr");
    rd(12'h001, 8'h16, "read_id_dev");
    wr(12'h000, 8'hFF);
`else
    wr(12'h000, 8'h90);
    rd(12'h0FF, 8'h11, "cmd_90_read_array");
`endif

    // Abort an erase of block 2 after 20 bytes with a one-cycle NF_RP pulse.
    wr(12'h000, 8'h20);
    wr(12'h250, 8'hD0);
    repeat (20) @(posedge clk);
    #1 nf.NF_RP = 1'b0;
    @(posedge clk); #1;
    nf.NF_RP = 1'b1;
    @(negedge clk);
    chk("rp_abort_sts", nf.NF_STS, 1'b1);
    @(posedge clk); #1;
    rd(12'h2F0, 8'h5A, "abort_untouched_0x2f0");
    rd(12'h200, 8'hFF, "abort_erased_0x200");
    rd(12'h213, 8'hFF, "abort_erased_0x213");
    rd(12'h214, 8'hFF, "abort_unerased_0x214");

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_emulator.md
Name: flash_emulator

Overview:
- Synthesizable byte-wide parallel NOR flash responder, Intel StrataFlash-style command subset.
- Connects pin-for-pin to the NF_* side of the flash bridge and stands in for the real device in on-chip loopback and simulation.
- Backed by an internal RAM array. Decodes command writes, emulates program, erase and status timing, and drives read data and NF_STS.

Parameters:
- ADDR_W, 12, address width; array depth is 2**ADDR_W bytes.
- BLOCK_W, 8, low address bits inside one erase block (block = 256 bytes).
- PROG_CYCLES, 16, busy cycles per byte program (minimum 1).
- DEVICE_ID, 8'h16, identifier byte returned at A0=1 (feature only).

Ports:
- CLK_50MHZ  input  1  system clock; all pins sampled on its rising edge.
- RST  input  1  synchronous, active-high reset.
- NF_CE  input  1  chip enable, active low.
- NF_OE  input  1  output enable, active low.
- NF_WE  input  1  write enable, active low.
- NF_RP  input  1  device reset/power-down, active low.
- NF_WP  input  1  low = first and last blocks protected.
- NF_A  input  ADDR_W  byte address.
- NF_D_IN  input  8  data from bridge.
- NF_D_OUT  output  8  read data.
- NF_D_OE  output  1  NF_D_OUT valid / tristate enable.
- NF_STS  output  1  1 = ready, 0 = busy.

Behaviour:
- Reset: RST=1 or NF_RP=0 forces the following state, with effect visible the next cycle.
  - mode=READ_ARRAY, SR=8'h80, NF_D_OE=0, NF_D_OUT=8'h00, NF_STS=1.
  - Any program or erase in progress is aborted.
  - Array contents are not touched; bytes already erased stay 8'hFF. Power-up array content is all 8'hFF.
- Write strobe:
  - A/D are captured every cycle in which NF_CE=0 and NF_WE=0.
  - A write event is the first cycle with NF_WE=1 after such a cycle; it uses the last captured A/D.
  - Write events are ignored while BUSY.
- Read:
  - While NF_CE=0, NF_OE=0 and NF_WE=1, NF_D_OE=1 and NF_D_OUT is updated with 1-cycle latency from A and the current mode.
  - NF_D_OE falls the cycle after NF_CE or NF_OE goes high.
  - Read source by mode: READ_ARRAY → mem[A]; READ_STATUS, PROG_SETUP, ERASE_SETUP or BUSY → SR.
- Command decode (write event in an idle mode):
  - 8'hFF → READ_ARRAY.
  - 8'h70 → READ_STATUS.
  - 8'h50 → clear SR[5:1], READ_STATUS.
  - 8'h40 or 8'h10 → PROG_SETUP.
  - 8'h20 → ERASE_SETUP.
  - Any other value → READ_ARRAY.
- PROG_SETUP:
  - Next write event carries the data.
  - If the target block is protected (NF_WP=0 and block index 0 or max): SR|=8'h12, no array change, go to READ_STATUS.
  - Otherwise enter BUSY_PROG: SR7=0, NF_STS=0 for PROG_CYCLES cycles.
  - On the last busy cycle, mem[A] <= mem[A] & D (bits only clear).
  - The following cycle: SR7=1, NF_STS=1, mode=READ_STATUS.
- ERASE_SETUP:
  - Next write must be 8'hD0, else SR|=8'h30 and go to READ_STATUS.
  - On a protected block: SR|=8'h22, no array change, go to READ_STATUS.
  - Otherwise BUSY_ERASE writes 8'hFF to one byte per cycle, offset 0 to 2**BLOCK_W-1 of block A[ADDR_W-1:BLOCK_W], so busy lasts 2**BLOCK_W cycles.
  - Then SR7=1, NF_STS=1, mode=READ_STATUS.
- SR bits: SR7 ready, SR5 erase error, SR4 program error, SR1 block locked. All other bits are 0.
- Errors stick until an 8'h50 command or reset.
- RST or NF_RP=0 asserted in the same cycle as a write event: reset wins.

Optional Feature:
- Macro: FLASH_EMU_READ_ID_EN.
- Enabled:
  - Command 8'h90 enters READ_ID mode.
  - Reads return 8'h89 for A[0]=0 and DEVICE_ID for A[0]=1.
  - 8'hFF exits READ_ID.
- Disabled: 8'h90 is an unknown command and goes to READ_ARRAY. The READ_ID logic is not synthesized.

Test Plan:
- Reset, then read A=0x000 → NF_D_OE=1 one cycle after OE low, NF_D_OUT=8'hFF, NF_STS=1.
- Write 8'h40, then 8'hA5 at A=0x123 → NF_STS=0 for exactly 16 cycles, status read 8'h80; after 8'hFF, read 0x123 returns 8'hA5.
- Program 8'h3C over 0x123 (holding 8'hA5) → reads 8'h24.
- Write 8'h20, then 8'hD0 at 0x150 → busy for 256 cycles, 0x100–0x1FF read 8'hFF, 0x0FF and 0x200 unchanged.
- Error sequences:
  - 8'h20 then 8'h55 → SR=8'hB0; 8'h50 → SR=8'h80.
  - With NF_WP=0, program at 0x010 → SR=8'h92, mem unchanged.
- NF_RP=0 for one cycle mid-erase → next cycle NF_STS=1, mode READ_ARRAY; already-erased bytes read 8'hFF, the rest keep their old values.
